regfile_sb: RTL

Parametrised integer register file with write-to-read bypass and a per-register busy scoreboard, replacing the fixed 32x32 negedge-write register file in the CPU datapath. It sits between decode (two read ports plus issue-time destination marking) and writeback (one write port). It reports per-operand readiness so the pipeline controller can stall on RAW hazards, and exposes a debug read port for the test harness.

---
 rtl/regfile_sb_if.sv | 32 +++
 rtl/regfile_sb.sv | 98 +++++++++
 2 files changed

// File: rtl/regfile_sb_if.sv
// Decode/writeback/debug bundle for regfile_sb.
// The master drives addresses and controls; the slave returns read data, readiness and busy count.
interface regfile_sb_if #(
    parameter int XLEN = 32,
    parameter int AW   = 5
);
    logic [AW-1:0]   rd_addr_a;
    logic [AW-1:0]   rd_addr_b;
    logic [XLEN-1:0] rd_data_a;
    logic [XLEN-1:0] rd_data_b;
    logic            rd_ready_a;
    logic            rd_ready_b;
    logic            iss_en;
    logic [AW-1:0]   iss_addr;
    logic            wb_en;
    logic [AW-1:0]   wb_addr;
    logic [XLEN-1:0] wb_data;
    logic            flush;
    logic [AW:0]     busy_cnt;
    logic [AW-1:0]   dbg_addr;
    logic [XLEN-1:0] dbg_data;

    modport master (
        output rd_addr_a, rd_addr_b, iss_en, iss_addr, wb_en, wb_addr, wb_data, flush, dbg_addr,
        input  rd_data_a, rd_data_b, rd_ready_a, rd_ready_b, busy_cnt, dbg_data
    );

    modport slave (
        input  rd_addr_a, rd_addr_b, iss_en, iss_addr, wb_en, wb_addr, wb_data, flush, dbg_addr,
        output rd_data_a, rd_data_b, rd_ready_a, rd_ready_b, busy_cnt, dbg_data
    );
endinterface

// File: rtl/regfile_sb.sv
// Integer register file with writeback-to-read bypass and a per-register busy scoreboard
// used by the pipeline controller to stall on RAW hazards.
module regfile_sb #(
    parameter int XLEN     = 32,
    parameter int NREG     = 32,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input logic         clk,
    input logic         rst,
    regfile_sb_if.slave bus
);
    localparam int AW = $clog2(NREG);

    logic [XLEN-1:0] regs_q [NREG];
    logic [NREG-1:0] busy_q;
    logic [NREG-1:0] busy_d;
    logic [AW:0]     busy_cnt_q;
    logic [AW:0]     busy_cnt_d;

    logic wb_ok;
    logic iss_ok;
    logic zero_a;
    logic zero_b;
    logic hit_a;
    logic hit_b;

    // Register 0 ignores writes and issues when it is hardwired to zero.
    assign wb_ok  = bus.wb_en  && !((ZERO_REG != 0) && (bus.wb_addr  == '0));
    assign iss_ok = bus.iss_en && !((ZERO_REG != 0) && (bus.iss_addr == '0));

    assign zero_a = (ZERO_REG != 0) && (bus.rd_addr_a == '0);
    assign zero_b = (ZERO_REG != 0) && (bus.rd_addr_b == '0);
    assign hit_a  = (BYPASS != 0) && bus.wb_en && (bus.wb_addr == bus.rd_addr_a);
    assign hit_b  = (BYPASS != 0) && bus.wb_en && (bus.wb_addr == bus.rd_addr_b);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wb_ok) begin
            regs_q[bus.wb_addr] <= bus.wb_data;
        end
    end

    // Issue is applied after writeback so a same-address pair leaves the new producer pending.
    always_comb begin
        busy_d = busy_q;
        if (bus.flush) begin
            busy_d = '0;
        end else begin
            if (wb_ok) begin
                busy_d[bus.wb_addr] = 1'b0;
            end
            if (iss_ok) begin
                busy_d[bus.iss_addr] = 1'b1;
            end
        end
    end

    always_comb begin
        busy_cnt_d = '0;
        for (int i = 0; i < NREG; i++) begin
            busy_cnt_d = busy_cnt_d + (AW+1)'(busy_d[i]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q     <= '0;
            busy_cnt_q <= '0;
        end else begin
            busy_q     <= busy_d;
            busy_cnt_q <= busy_cnt_d;
        end
    end

    always_comb begin
        bus.rd_data_a = regs_q[bus.rd_addr_a];
        if (zero_a) begin
            bus.rd_data_a = '0;
        end else if (hit_a) begin
            bus.rd_data_a = bus.wb_data;
        end
        bus.rd_data_b = regs_q[bus.rd_addr_b];
        if (zero_b) begin
            bus.rd_data_b = '0;
        end else if (hit_b) begin
            bus.rd_data_b = bus.wb_data;
        end
    end

    assign bus.rd_ready_a = !busy_q[bus.rd_addr_a] || hit_a || zero_a;
    assign bus.rd_ready_b = !busy_q[bus.rd_addr_b] || hit_b || zero_b;
    assign bus.busy_cnt   = busy_cnt_q;
    assign bus.dbg_data   = regs_q[bus.dbg_addr];
endmodule
